// File: rtl/apb_master.sv
// apb_master: single-command APB requester with wait-state timeout and response hold
module apb_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
    state_t     state, state_n;
    logic [7:0] cnt;
    logic       expire;
    // next-state decode; pready wins over an expiring wait count
    always_comb begin
        expire  = 1'b0;
        state_n = state;
        expire  = (state == ACCESS) && !pready && (cnt == LAST);
        state_n = state == IDLE   ? (cmd_valid ? SETUP : IDLE) :
                  state == SETUP  ? ACCESS :
                  state == ACCESS ? ((pready || expire) ? RESP : ACCESS) :
                                    (rsp_ready ? IDLE : RESP);
    end
    // state register
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) state <= IDLE;
        else        state <= state_n;
    end
    // registered outputs, address/data capture, wait counter and response capture
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            cmd_ready   <= 1'b1;
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            cnt         <= '0;
        end else begin
            cmd_ready <= state_n == IDLE;
            psel      <= state_n == SETUP || state_n == ACCESS;
            penable   <= state_n == ACCESS;
            rsp_valid <= state_n == RESP;
            if (state == IDLE && cmd_valid) begin
                paddr  <= cmd_addr;
                pwrite <= cmd_write;
                pwdata <= cmd_write ? cmd_wdata : '0;
            end
            if (state == SETUP) cnt <= '0;
            if (state == ACCESS) begin
                if (pready) begin
                    rsp_rdata   <= pwrite ? '0 : prdata;
                    rsp_err     <= pslverr;
                    rsp_timeout <= 1'b0;
                end else if (expire) begin
                    rsp_rdata   <= '0;
                    rsp_err     <= 1'b1;
                    rsp_timeout <= 1'b1;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed checks of apb_master transfers, waits, timeout, errors and reset
module tb_apb_master;
    logic        pclk = 1'b0;
    logic        preset = 1'b1;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata, paddr, pwdata;
    logic        psel, penable, pwrite;
    logic [31:0] prdata = '0;
    logic        pready = 1'b0, pslverr = 1'b0;
    int          total = 0, passed = 0;
    int          n;

    apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    // issue a command from IDLE; returns #1 after the accept edge (in SETUP)
    task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
        check("cmd_ready_pre", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        step();
        cmd_valid = 1'b0;
        cmd_addr  = 32'h5555_AAAA;
        cmd_wdata = 32'hAAAA_5555;
        check("setup_psel", psel, 1);
        check("setup_penable", penable, 0);
    endtask

    // from SETUP, run ACCESS with pready high in cycle ready_at (0 = never); n = ACCESS cycles seen
    task automatic run_access(input int ready_at, input logic err, input logic [31:0] rd, output int cnt);
        cnt = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (!penable) break;
            cnt++;
            pready  = (cnt == ready_at);
            pslverr = (cnt == ready_at) && err;
            prdata  = (cnt == ready_at) ? rd : 32'hDEAD_BEEF;
        end
        pready  = 1'b0;
        pslverr = 1'b0;
        check("resp_valid", rsp_valid, 1);
        check("resp_psel", psel, 0);
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        step();
        check("idle_rsp_valid", rsp_valid, 0);
        check("idle_cmd_ready", cmd_ready, 1);
    endtask

    initial begin
        #12;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_paddr", paddr, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        @(posedge pclk);
        #1 preset = 1'b0;
        step();

        // zero-wait write
        do_cmd(1'b1, 32'hFFFF_F010, 32'hFFFF_FFFF);
        check("w_paddr_s", paddr, 32'hFFFF_F010);
        check("w_pwdata_s", pwdata, 32'hFFFF_FFFF);
        check("w_pwrite", pwrite, 1);
        check("w_cmd_ready", cmd_ready, 0);
        check("w_rsp_valid_s", rsp_valid, 0);
        pready = 1'b1;
        step();
        check("w_access_psel", psel, 1);
        check("w_access_penable", penable, 1);
        check("w_paddr_a", paddr, 32'hFFFF_F010);
        check("w_pwdata_a", pwdata, 32'hFFFF_FFFF);
        check("w_rsp_valid_a", rsp_valid, 0);
        step();
        pready = 1'b0;
        check("w_rsp_valid", rsp_valid, 1);
        check("w_rsp_err", rsp_err, 0);
        check("w_penable", penable, 0);
        check("w_paddr_hold", paddr, 32'hFFFF_F010);
        finish_rsp();

        // zero-wait read
        do_cmd(1'b0, 32'hFFFF_F100, 32'h1111_2222);
        check("r_pwdata_s", pwdata, 0);
        check("r_pwrite", pwrite, 0);
        pready = 1'b1;
        prdata = 32'hFFF0_0010;
        step();
        check("r_pwdata_a", pwdata, 0);
        step();
        pready = 1'b0;
        check("r_rsp_valid", rsp_valid, 1);
        check("r_rsp_rdata", rsp_rdata, 32'hFFF0_0010);
        finish_rsp();
        check("r_rdata_retained", rsp_rdata, 32'hFFF0_0010);

        // read with three wait cycles
        do_cmd(1'b0, 32'h0000_0040, 32'h0);
        run_access(4, 1'b0, 32'h1234_5678, n);
        check("wait_access_cycles", n, 4);
        check("wait_rsp_rdata", rsp_rdata, 32'h1234_5678);
        check("wait_rsp_err", rsp_err, 0);
        finish_rsp();

        // timeout with pready held low
        do_cmd(1'b0, 32'h0000_0080, 32'h0);
        run_access(0, 1'b0, 32'h0, n);
        check("to_access_cycles", n, 16);
        check("to_rsp_err", rsp_err, 1);
        check("to_rsp_timeout", rsp_timeout, 1);
        check("to_rsp_rdata", rsp_rdata, 0);
        finish_rsp();

        // pready on the final permitted cycle completes normally
        do_cmd(1'b0, 32'h0000_00C0, 32'h0);
        run_access(16, 1'b0, 32'hCAFE_0016, n);
        check("late_access_cycles", n, 16);
        check("late_rsp_err", rsp_err, 0);
        check("late_rsp_timeout", rsp_timeout, 0);
        check("late_rsp_rdata", rsp_rdata, 32'hCAFE_0016);
        finish_rsp();

        // slave error with response back-pressure and ignored commands
        do_cmd(1'b1, 32'h0000_0100, 32'h0BAD_0BAD);
        rsp_ready = 1'b0;
        run_access(1, 1'b1, 32'h0, n);
        cmd_valid = 1'b1;
        cmd_addr  = 32'h0000_0200;
        for (int i = 0; i < 5; i++) begin
            check("err_rsp_valid", rsp_valid, 1);
            check("err_cmd_ready", cmd_ready, 0);
            check("err_rsp_err", rsp_err, 1);
            check("err_rsp_timeout", rsp_timeout, 0);
            check("err_paddr_hold", paddr, 32'h0000_0100);
            if (i < 4) step();
        end
        cmd_valid = 1'b0;
        finish_rsp();
        check("err_retained", rsp_err, 1);
        check("err_paddr_kept", paddr, 32'h0000_0100);

        // asynchronous reset during ACCESS
        do_cmd(1'b0, 32'h0000_0300, 32'h0);
        step();
        check("rst_mid_penable_pre", penable, 1);
        #2 preset = 1'b1;
        #1;
        check("rst_mid_psel", psel, 0);
        check("rst_mid_penable", penable, 0);
        check("rst_mid_cmd_ready", cmd_ready, 1);
        check("rst_mid_paddr", paddr, 0);
        check("rst_mid_rsp_err", rsp_err, 0);
        @(posedge pclk);
        #1 preset = 1'b0;
        step();
        check("rst_post_rsp_valid", rsp_valid, 0);
        check("rst_post_psel", psel, 0);
        do_cmd(1'b1, 32'h0000_0400, 32'h1357_9BDF);
        check("rst_post_pwdata", pwdata, 32'h1357_9BDF);
        run_access(1, 1'b0, 32'h0, n);
        check("rst_post_cycles", n, 1);
        check("rst_post_rsp_err", rsp_err, 0);
        check("rst_post_rsp_rdata", rsp_rdata, 0);
        finish_rsp();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning APB address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning APB data width.
REQ-003 The block SHALL have parameter TIMEOUT, default 16, legal range 2..255, meaning the maximum ACCESS wait cycles with pready low.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 Ports SHALL be:
- pclk  in  1  clock; all state updates on the rising edge.
- preset  in  1  asynchronous active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  transfer address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_W  read data.
- rsp_err  out  1  pslverr or timeout.
- rsp_timeout  out  1  transfer ended by timeout.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB ready; tie high for zero-wait responders.
- pslverr  in  1  APB error; tie low if the responder has none.

Function
REQ-006 The FSM SHALL have states IDLE, SETUP, ACCESS and RESP, all outputs registered.
REQ-007 cmd_ready SHALL be 1 only in IDLE.
REQ-008 On an edge in IDLE with cmd_valid=1, the block SHALL do all of the following:
- latch cmd_addr into paddr and cmd_write into pwrite;
- latch cmd_wdata into pwdata for writes, or 0 for reads;
- enter SETUP.
REQ-009 In SETUP, outputs SHALL be psel=1, penable=0; the next edge SHALL enter ACCESS unconditionally.
REQ-010 In ACCESS, outputs SHALL be psel=1, penable=1.
REQ-011 paddr, pwrite and pwdata SHALL be stable from SETUP through the last ACCESS cycle, and SHALL hold their values until the next accept.
REQ-012 On an ACCESS edge with pready=1, the block SHALL do all of the following:
- set rsp_rdata to prdata for reads, or 0 for writes;
- set rsp_err to pslverr and rsp_timeout to 0;
- enter RESP.
REQ-013 A wait counter SHALL clear on entry to ACCESS and increment on each ACCESS edge with pready=0.
REQ-014 On the ACCESS edge where pready=0 and the counter equals TIMEOUT-1, the block SHALL do all of the following:
- abort the transfer and enter RESP;
- set rsp_rdata=0, rsp_err=1, rsp_timeout=1.
REQ-015 If pready rises on the same edge that would time out, REQ-012 SHALL take priority.
REQ-016 In RESP, outputs SHALL be psel=0, penable=0, rsp_valid=1; rsp_* SHALL hold until an edge with rsp_ready=1, which enters IDLE.
REQ-017 rsp_valid SHALL be 0 in all states other than RESP.
REQ-018 rsp_rdata, rsp_err and rsp_timeout SHALL retain their last values after leaving RESP.
REQ-019 Minimum transfer latency SHALL be: accept edge, +1 SETUP, +1 ACCESS, rsp_valid high 2 cycles after accept.
REQ-020 Minimum command spacing SHALL be 4 cycles when rsp_ready is held high.
REQ-021 Command inputs SHALL be ignored outside IDLE.
REQ-022 pslverr and prdata SHALL be ignored except on an ACCESS edge with pready=1.

Reset
REQ-023 While preset=1, the block SHALL asynchronously force all of the following:
- state IDLE and wait counter 0;
- psel=0, penable=0, pwrite=0, paddr=0, pwdata=0;
- cmd_ready=1 (IDLE);
- rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0.
REQ-024 A reset asserted mid-SETUP, mid-ACCESS or in RESP SHALL abort the transfer with no response; the first accept after release SHALL behave as from power-up.

Verification
REQ-025 Bench SHALL cover: write to 0xFFFF_F010, wdata 0xFFFF_FFFF, pready=1 -> one SETUP cycle then one ACCESS cycle, paddr/pwdata stable, rsp_valid=1 two cycles after accept, rsp_err=0.
REQ-026 Bench SHALL cover: read 0xFFFF_F100, responder returns 0xFFF0_0010 -> rsp_rdata=0xFFF0_0010 and pwdata=0 during the transfer.
REQ-027 Bench SHALL cover: read with pready low for 3 ACCESS cycles, prdata=0x1234_5678 on the ready edge -> ACCESS lasts 4 cycles and rsp_rdata=0x1234_5678.
REQ-028 Bench SHALL cover: TIMEOUT=16, pready held 0 -> abort after 16 ACCESS cycles with rsp_err=1, rsp_timeout=1, rsp_rdata=0; also pready=1 on the 16th cycle -> normal completion.
REQ-029 Bench SHALL cover: pslverr=1 with pready=1, and rsp_ready held 0 for 5 cycles -> rsp_err=1, rsp_timeout=0, rsp_valid held for 5 cycles, cmd_ready=0 throughout.
REQ-030 Bench SHALL cover: preset pulsed during ACCESS -> psel=0 and penable=0 immediately, no rsp_valid, then a following write completes normally.
